prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program (length, instruction words, XOR
// checksum) and writes it into program memory while holding the processor
// core in reset. The core is released only after a load whose checksum matches.
module prog_loader #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 core_rstn,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Counter/length need one extra bit so a full-depth length fits.
    localparam int            CW      = ADDR_SIZE + 1;
    localparam logic [31:0]   DEPTH   = 32'd1 << ADDR_SIZE;
    localparam logic [CW-1:0] CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    // Running checksum step: XOR accumulation of instruction words.
    function automatic logic [DATA_SIZE-1:0] csum_update(
        input logic [DATA_SIZE-1:0] acc,
        input logic [DATA_SIZE-1:0] word
    );
        return acc ^ word;
    endfunction

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          len_q;
    logic [DATA_SIZE-1:0]   csum_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   mem_we_q;
    logic [ADDR_SIZE-1:0]   mem_addr_q;
    logic [DATA_SIZE-1:0]   mem_wdata_q;
    logic                   core_rstn_q;
    logic                   load_done_q;
    logic                   load_err_q;

    logic                   xfer_s;
    logic [31:0]            len_ext_s;
    logic                   len_ok_s;
    logic [CW-1:0]          cnt_inc_s;

    assign xfer_s    = in_valid && in_ready_q;
    assign len_ext_s = 32'(in_data);
    assign len_ok_s  = (len_ext_s >= 32'd1) && (len_ext_s <= DEPTH);
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Loader FSM: state, counters, checksum and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rstn_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse following a LOAD transfer.
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        // Re-hold the core on the same edge a (re)load begins.
                        state_q     <= HDR;
                        cnt_q       <= '0;
                        csum_q      <= '0;
                        core_rstn_q <= 1'b0;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                HDR: begin
                    if (xfer_s) begin
                        if (len_ok_s) begin
                            state_q <= LOAD;
                            len_q   <= len_ext_s[CW-1:0];
                        end else begin
                            state_q     <= ERR;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            core_rstn_q <= 1'b0;
                            load_err_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= HDR;
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q[ADDR_SIZE-1:0];
                        mem_wdata_q <= in_data;
                        csum_q      <= csum_update(csum_q, in_data);
                        cnt_q       <= cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            state_q <= CHK;
                        end else begin
                            state_q <= LOAD;
                        end
                    end else begin
                        state_q <= LOAD;
                    end
                end
                CHK: begin
                    if (xfer_s) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q     <= DONE;
                            core_rstn_q <= 1'b1;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q     <= ERR;
                            core_rstn_q <= 1'b0;
                            load_err_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= CHK;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    core_rstn_q <= 1'b0;
                    load_done_q <= 1'b0;
                    load_err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rstn = core_rstn_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
